// File: rtl/grf_wb_scheduler.sv
// Writeback arbiter for the single GRF write port: ALU has fixed priority, MDU waits.
// The pending scoreboard stalls issue on RAW/WAW hazards until the write commits.
module grf_wb_scheduler #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        iss_valid,
   input  logic [4:0]  iss_rs,
   input  logic [4:0]  iss_rt,
   input  logic        iss_use_rs,
   input  logic        iss_use_rt,
   input  logic        iss_wr,
   input  logic [4:0]  iss_rd,
   input  logic        iss_long,
   input  logic        mdu_busy,
   output logic        iss_stall,
   input  logic        alu_wb_valid,
   input  logic [4:0]  alu_wb_rd,
   input  logic [31:0] alu_wb_data,
   input  logic [31:0] alu_wb_pc,
   input  logic        mdu_wb_valid,
   input  logic [4:0]  mdu_wb_rd,
   input  logic [31:0] mdu_wb_data,
   input  logic [31:0] mdu_wb_pc,
   output logic        mdu_wb_ready,
   output logic        grf_we,
   output logic [4:0]  grf_rw,
   output logic [31:0] grf_wd,
   output logic [31:0] grf_pc,
   output logic [31:0] pending
);

   localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] LIMIT_C = CW'(STARVE_LIMIT);

   logic [31:0]   pending_q, pending_d;
   logic [CW-1:0] starve_q, starve_d;
   logic          we_q, we_d;
   logic [4:0]    rw_q, rw_d;
   logic [31:0]   wd_q, wd_d;
   logic [31:0]   pc_q, pc_d;

   logic raw_rs, raw_rt, waw, structural, starved, hazard, accept;
   logic grant_alu, grant_mdu;

   always_comb begin
      raw_rs     = iss_use_rs && (iss_rs != 5'd0) && pending_q[iss_rs];
      raw_rt     = iss_use_rt && (iss_rt != 5'd0) && pending_q[iss_rt];
      waw        = iss_wr && (iss_rd != 5'd0) && pending_q[iss_rd];
      structural = iss_long && mdu_busy;
      starved    = (starve_q >= LIMIT_C);
      hazard     = raw_rs || raw_rt || waw || structural || starved;
      iss_stall  = reset || (iss_valid && hazard);
      accept     = iss_valid && !iss_stall;

      grant_alu    = alu_wb_valid;
      grant_mdu    = !alu_wb_valid && mdu_wb_valid && !reset;
      mdu_wb_ready = grant_mdu;

      // Clear for the committing write first so a same-edge set takes precedence.
      pending_d = pending_q;
      if (we_q) pending_d[rw_q] = 1'b0;
      if (accept && iss_wr && (iss_rd != 5'd0)) pending_d[iss_rd] = 1'b1;
      pending_d[0] = 1'b0;

      starve_d = starve_q;
      if (!mdu_wb_valid || grant_mdu) starve_d = '0;
      else if (alu_wb_valid && (starve_q < LIMIT_C)) starve_d = starve_q + 1'b1;

      we_d = 1'b0;
      rw_d = rw_q;
      wd_d = wd_q;
      pc_d = pc_q;
      if (grant_alu) begin
         we_d = (alu_wb_rd != 5'd0);
         rw_d = alu_wb_rd;
         wd_d = alu_wb_data;
         pc_d = alu_wb_pc;
      end else if (grant_mdu) begin
         we_d = (mdu_wb_rd != 5'd0);
         rw_d = mdu_wb_rd;
         wd_d = mdu_wb_data;
         pc_d = mdu_wb_pc;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pending_q <= '0;
         starve_q  <= '0;
         we_q      <= 1'b0;
         rw_q      <= '0;
         wd_q      <= '0;
         pc_q      <= '0;
      end else begin
         pending_q <= pending_d;
         starve_q  <= starve_d;
         we_q      <= we_d;
         rw_q      <= rw_d;
         wd_q      <= wd_d;
         pc_q      <= pc_d;
      end
   end

   assign grf_we  = we_q;
   assign grf_rw  = rw_q;
   assign grf_wd  = wd_q;
   assign grf_pc  = pc_q;
   assign pending = pending_q;

endmodule

// File: tb/tb_grf_wb_scheduler.sv
// Bench for grf_wb_scheduler: directed scenarios then random traffic, all against a
// cycle-level reference model of scoreboard, arbitration and starvation rules.
module tb_grf_wb_scheduler;

   localparam int LIMIT = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        iss_valid, iss_use_rs, iss_use_rt, iss_wr, iss_long, mdu_busy;
   logic [4:0]  iss_rs, iss_rt, iss_rd;
   logic        iss_stall;
   logic        alu_wb_valid, mdu_wb_valid, mdu_wb_ready;
   logic [4:0]  alu_wb_rd, mdu_wb_rd;
   logic [31:0] alu_wb_data, alu_wb_pc, mdu_wb_data, mdu_wb_pc;
   logic        grf_we;
   logic [4:0]  grf_rw;
   logic [31:0] grf_wd, grf_pc, pending;

   grf_wb_scheduler #(.STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .reset(reset),
      .iss_valid(iss_valid), .iss_rs(iss_rs), .iss_rt(iss_rt),
      .iss_use_rs(iss_use_rs), .iss_use_rt(iss_use_rt),
      .iss_wr(iss_wr), .iss_rd(iss_rd), .iss_long(iss_long), .mdu_busy(mdu_busy),
      .iss_stall(iss_stall),
      .alu_wb_valid(alu_wb_valid), .alu_wb_rd(alu_wb_rd), .alu_wb_data(alu_wb_data), .alu_wb_pc(alu_wb_pc),
      .mdu_wb_valid(mdu_wb_valid), .mdu_wb_rd(mdu_wb_rd), .mdu_wb_data(mdu_wb_data), .mdu_wb_pc(mdu_wb_pc),
      .mdu_wb_ready(mdu_wb_ready),
      .grf_we(grf_we), .grf_rw(grf_rw), .grf_wd(grf_wd), .grf_pc(grf_pc), .pending(pending)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model state: set of outstanding destinations, streak of denied MDU cycles,
   // and the write currently presented to the register file.
   logic [31:0] m_pend;
   int          m_streak;
   logic        m_we;
   logic [4:0]  m_rw;
   logic [31:0] m_wd, m_pc;
   logic        m_took;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   function automatic logic uses(input logic en, input logic [4:0] r);
      return en && (r != 5'd0) && m_pend[r];
   endfunction

   task automatic tick();
      logic stall_e, ready_e;
      logic [31:0] np;
      #2;
      stall_e = reset || (iss_valid && (uses(iss_use_rs, iss_rs) || uses(iss_use_rt, iss_rt) ||
                 uses(iss_wr, iss_rd) || (iss_long && mdu_busy) || (m_streak >= LIMIT)));
      ready_e = !reset && !alu_wb_valid && mdu_wb_valid;
      check("iss_stall", iss_stall, stall_e);
      check("mdu_wb_ready", mdu_wb_ready, ready_e);
      m_took = ready_e;
      @(posedge clk);
      if (reset) begin
         m_pend = '0; m_streak = 0; m_we = 0; m_rw = '0; m_wd = '0; m_pc = '0;
      end else begin
         np = m_pend;
         if (m_we) np[m_rw] = 1'b0;
         if (iss_valid && !stall_e && iss_wr && iss_rd != 5'd0) np[iss_rd] = 1'b1;
         m_pend = np;
         m_streak = (mdu_wb_valid && alu_wb_valid) ? ((m_streak + 1 > LIMIT) ? LIMIT : m_streak + 1) : 0;
         if (alu_wb_valid) begin
            m_we = (alu_wb_rd != 0); m_rw = alu_wb_rd; m_wd = alu_wb_data; m_pc = alu_wb_pc;
         end else if (mdu_wb_valid) begin
            m_we = (mdu_wb_rd != 0); m_rw = mdu_wb_rd; m_wd = mdu_wb_data; m_pc = mdu_wb_pc;
         end else m_we = 1'b0;
      end
      #1;
      check("grf_we", grf_we, m_we);
      check("grf_rw", grf_rw, m_rw);
      check("grf_wd", grf_wd, m_wd);
      check("grf_pc", grf_pc, m_pc);
      check("pending", pending, m_pend);
   endtask

   task automatic idle();
      reset = 0; iss_valid = 0; iss_rs = 0; iss_rt = 0; iss_use_rs = 0; iss_use_rt = 0;
      iss_wr = 0; iss_rd = 0; iss_long = 0; mdu_busy = 0;
      alu_wb_valid = 0; alu_wb_rd = 0; alu_wb_data = 0; alu_wb_pc = 0;
      mdu_wb_valid = 0; mdu_wb_rd = 0; mdu_wb_data = 0; mdu_wb_pc = 0;
   endtask

   task automatic issue_wr(input logic [4:0] rd, input logic lng);
      idle(); iss_valid = 1; iss_wr = 1; iss_rd = rd; iss_long = lng;
   endtask

   initial begin
      m_pend = '0; m_streak = 0; m_we = 0; m_rw = '0; m_wd = '0; m_pc = '0; m_took = 0;
      idle();
      reset = 1;
      @(posedge clk); #1;
      tick(); tick();
      check("reset_pending", pending, 32'h0);
      check("reset_grf_we", grf_we, 1'b0);
      reset = 0;
      #1 check("idle_stall", iss_stall, 1'b0);
      tick();

      // Writer to r5, ALU writeback three cycles later, reader of r5 waiting throughout.
      issue_wr(5'd5, 0);
      tick();
      check("r5_pending", pending[5], 1'b1);
      idle(); iss_valid = 1; iss_use_rs = 1; iss_rs = 5'd5;
      #1 check("raw_stall", iss_stall, 1'b1);
      tick(); tick();
      alu_wb_valid = 1; alu_wb_rd = 5'd5; alu_wb_data = 32'h1234; alu_wb_pc = 32'h400;
      tick();
      alu_wb_valid = 0;
      check("wb_we", grf_we, 1'b1);
      check("wb_rw", grf_rw, 32'd5);
      check("wb_wd", grf_wd, 32'h1234);
      #1 check("raw_stall_commit", iss_stall, 1'b1);
      tick();
      check("r5_cleared", pending[5], 1'b0);
      #1 check("raw_release", iss_stall, 1'b0);
      tick();

      // Simultaneous ALU (r3) and MDU (r7) writebacks.
      issue_wr(5'd3, 0); tick();
      issue_wr(5'd7, 1); tick();
      idle();
      alu_wb_valid = 1; alu_wb_rd = 5'd3; alu_wb_data = 32'hAAAA0003; alu_wb_pc = 32'h500;
      mdu_wb_valid = 1; mdu_wb_rd = 5'd7; mdu_wb_data = 32'hBBBB0007; mdu_wb_pc = 32'h504;
      #1 check("dual_ready0", mdu_wb_ready, 1'b0);
      tick();
      check("dual_first_rw", grf_rw, 32'd3);
      alu_wb_valid = 0;
      #1 check("dual_ready1", mdu_wb_ready, 1'b1);
      tick();
      check("dual_second_rw", grf_rw, 32'd7);
      mdu_wb_valid = 0;
      tick();
      check("dual_pending", pending, 32'h0);

      // ALU held for six cycles while MDU waits.
      idle(); iss_valid = 1;
      mdu_wb_valid = 1; mdu_wb_rd = 5'd10; mdu_wb_data = 32'hC0DE; mdu_wb_pc = 32'h600;
      for (int k = 1; k <= 6; k++) begin
         alu_wb_valid = 1; alu_wb_rd = 5'd20; alu_wb_data = 32'(k); alu_wb_pc = 32'h700 + 32'(k);
         #1 check("starve_stall", iss_stall, (k >= 5));
         tick();
      end
      alu_wb_valid = 0;
      #1 check("starve_grant", mdu_wb_ready, 1'b1);
      tick();
      mdu_wb_valid = 0;
      #1 check("starve_release", iss_stall, 1'b0);
      tick();

      // rd = 0 from the MDU, and a reader of r0.
      idle(); iss_valid = 1; iss_use_rs = 1; iss_rs = 5'd0;
      mdu_wb_valid = 1; mdu_wb_rd = 5'd0; mdu_wb_data = 32'hDEAD; mdu_wb_pc = 32'h800;
      #1 check("r0_stall", iss_stall, 1'b0);
      check("r0_ready", mdu_wb_ready, 1'b1);
      tick();
      check("r0_we", grf_we, 1'b0);
      idle();

      // Structural hazard, then WAW on r9.
      iss_valid = 1; iss_long = 1; mdu_busy = 1;
      #1 check("busy_stall", iss_stall, 1'b1);
      tick();
      issue_wr(5'd9, 0); tick();
      issue_wr(5'd9, 0);
      alu_wb_valid = 1; alu_wb_rd = 5'd9; alu_wb_data = 32'h99; alu_wb_pc = 32'h900;
      #1 check("waw_stall", iss_stall, 1'b1);
      tick();
      alu_wb_valid = 0;
      #1 check("waw_stall_commit", iss_stall, 1'b1);
      tick();
      #1 check("waw_release", iss_stall, 1'b0);
      tick();
      check("waw_reissued", pending[9], 1'b1);
      idle();
      alu_wb_valid = 1; alu_wb_rd = 5'd9; alu_wb_data = 32'h999; alu_wb_pc = 32'h904;
      tick(); idle(); tick();

      // Reset arriving together with a grant.
      issue_wr(5'd12, 0); tick();
      idle(); reset = 1;
      alu_wb_valid = 1; alu_wb_rd = 5'd12; alu_wb_data = 32'h1212; alu_wb_pc = 32'hA00;
      tick();
      check("rst_flight_we", grf_we, 1'b0);
      check("rst_flight_pending", pending, 32'h0);
      idle(); tick();

      // Random traffic; MDU result held stable until taken.
      for (int c = 0; c < 400; c++) begin
         logic keep_mdu;
         keep_mdu = mdu_wb_valid && !m_took;
         reset      = ($urandom_range(0, 59) == 0);
         iss_valid  = $urandom_range(0, 1);
         iss_rs     = 5'($urandom_range(0, 7));
         iss_rt     = 5'($urandom_range(0, 7));
         iss_rd     = 5'($urandom_range(0, 7));
         iss_use_rs = $urandom_range(0, 1);
         iss_use_rt = $urandom_range(0, 1);
         iss_wr     = $urandom_range(0, 1);
         iss_long   = ($urandom_range(0, 3) == 0);
         mdu_busy   = ($urandom_range(0, 3) == 0);
         alu_wb_valid = ($urandom_range(0, 2) != 0);
         alu_wb_rd    = 5'($urandom_range(0, 7));
         alu_wb_data  = $urandom;
         alu_wb_pc    = $urandom;
         if (!keep_mdu) begin
            mdu_wb_valid = ($urandom_range(0, 2) == 0);
            mdu_wb_rd    = 5'($urandom_range(0, 7));
            mdu_wb_data  = $urandom;
            mdu_wb_pc    = $urandom;
         end
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
